// File: rtl/irq_ctl.sv
// irq_ctl: interrupt controller in front of the FemtoRV32 interrupt_request input.
// Sources are captured per bit, either on a rising edge or as a level. Each source
// has an enable bit, and there is also a global enable. The lowest active index
// wins the vector, and reading the vector claims that source.
// Register window (addr = mem_addr[3:2]): 0 STATUS, 1 ENABLE, 2 PENDING (W1C), 3 VECTOR.
// Optional macro IRQ_SYNC_EN: passes every irq_in bit through a two-flop synchronizer.
module irq_ctl #(
  parameter int unsigned NUM_IRQ   = 8,
  parameter logic [15:0] EDGE_MASK = 16'h0000
) (
  input  logic               clk,
  input  logic               resetq,
  input  logic               select,
  input  logic               rd,
  input  logic [3:0]         we,
  input  logic [1:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out
);

  localparam logic [NUM_IRQ-1:0] EdgeSel = EDGE_MASK[NUM_IRQ-1:0];

  logic [NUM_IRQ-1:0] raw;
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] en_q, en_d;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] active;
  logic               gen_q, gen_d;
  logic               irq_q;
  logic               any_active;
  logic               wr_en;
  logic               claim;
  logic [3:0]         vec_idx;
  logic               unused_wdata;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer for asynchronous source pins
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign raw = sync2_q;
`else
  assign raw = irq_in;
`endif

  assign wr_en        = select && (we != 4'b0000);
  assign active       = pend_q & en_q & {NUM_IRQ{gen_q}};
  assign any_active   = |active;
  assign claim        = rd && select && (addr == 2'd3) && any_active;
  assign unused_wdata = ^wdata;

  // Priority encoder: lowest active index wins
  always_comb begin
    vec_idx = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) vec_idx = 4'(i);
    end
  end

  // Next-state for enables and pending bits; a new edge beats a same-cycle clear
  always_comb begin
    en_d   = en_q;
    gen_d  = gen_q;
    clr    = '0;
    pend_d = pend_q;
    if (wr_en && (addr == 2'd1)) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (we[i / 8]) en_d[i] = wdata[i];
      end
      if (we[3]) gen_d = wdata[31];
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (wr_en && (addr == 2'd2) && we[i / 8] && wdata[i]) clr[i] = 1'b1;
      if (claim && (vec_idx == 4'(i))) clr[i] = 1'b1;
      if (EdgeSel[i]) begin
        pend_d[i] = (raw[i] & ~prev_q[i]) | (pend_q[i] & ~clr[i]);
      end else begin
        pend_d[i] = raw[i];
      end
    end
  end

  // Register read mux, combinational on addr
  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: rdata[NUM_IRQ-1:0] = raw;
      2'd1: begin
        rdata[NUM_IRQ-1:0] = en_q;
        rdata[31]          = gen_q;
      end
      2'd2: rdata[NUM_IRQ-1:0] = pend_q;
      default: begin
        if (any_active) begin
          rdata[31]  = 1'b1;
          rdata[3:0] = vec_idx;
        end
      end
    endcase
  end

  // State registers; irq_out is registered from the active set
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      prev_q <= '0;
      pend_q <= '0;
      en_q   <= '0;
      gen_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= raw;
      pend_q <= pend_d;
      en_q   <= en_d;
      gen_q  <= gen_d;
      irq_q  <= any_active;
    end
  end

  assign irq_out = irq_q;

endmodule

// File: tb/tb_irq_ctl.sv
// Self-checking bench for irq_ctl: directed scenarios plus randomized traffic
// checked against a per-source behavioural model.
module tb_irq_ctl;
  localparam int N = 8;
  localparam logic [15:0] EDGE = 16'h00AB;  // sources 0,1,3,5,7 edge; 2,4,6 level
`ifdef IRQ_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic         clk = 1'b0;
  logic         resetq;
  logic         select, rd;
  logic [3:0]   we;
  logic [1:0]   addr;
  logic [31:0]  wdata, rdata;
  logic [N-1:0] irq_in;
  logic         irq_out;

  int n_vec = 0;
  int n_bad = 0;

  irq_ctl #(.NUM_IRQ(N), .EDGE_MASK(EDGE)) dut (
    .clk     (clk),
    .resetq  (resetq),
    .select  (select),
    .rd      (rd),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq_in  (irq_in),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_prev, m_pend, m_en;
  logic         m_gen, m_irq;
`ifdef IRQ_SYNC_EN
  logic [N-1:0] m_s1, m_s2;
`endif

  function automatic logic [N-1:0] m_raw();
`ifdef IRQ_SYNC_EN
    return m_s2;
`else
    return irq_in;
`endif
  endfunction

  // Index of the winning source, or -1 if nothing is active
  function automatic int m_vec();
    for (int i = 0; i < N; i++) begin
      if (m_pend[i] && m_en[i] && m_gen) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [1:0] a);
    logic [31:0] r;
    int v;
    r = 32'h0;
    v = m_vec();
    case (a)
      2'd0: r = 32'(m_raw());
      2'd1: begin r = 32'(m_en); r[31] = m_gen; end
      2'd2: r = 32'(m_pend);
      default: if (v >= 0) r = 32'h8000_0000 | 32'(v);
    endcase
    return r;
  endfunction

  function automatic logic [N-1:0] m_next_pend();
    logic [N-1:0] rw, nx;
    logic wr, rise, w1c, clm;
    int v;
    rw = m_raw();
    v  = m_vec();
    wr = select && (we != 4'b0);
    for (int i = 0; i < N; i++) begin
      if (!EDGE[i]) begin
        nx[i] = rw[i];
      end else begin
        rise = rw[i] && !m_prev[i];
        w1c  = wr && (addr == 2'd2) && we[i / 8] && wdata[i];
        clm  = rd && select && (addr == 2'd3) && (v == i);
        if (rise)            nx[i] = 1'b1;
        else if (w1c || clm) nx[i] = 1'b0;
        else                 nx[i] = m_pend[i];
      end
    end
    return nx;
  endfunction

  function automatic logic [N-1:0] m_next_en();
    logic [N-1:0] e;
    e = m_en;
    if (select && (we != 4'b0) && (addr == 2'd1)) begin
      for (int i = 0; i < N; i++) if (we[i / 8]) e[i] = wdata[i];
    end
    return e;
  endfunction

  function automatic logic m_next_gen();
    if (select && (we != 4'b0) && (addr == 2'd1) && we[3]) return wdata[31];
    return m_gen;
  endfunction

  always @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      m_prev <= '0;
      m_pend <= '0;
      m_en   <= '0;
      m_gen  <= 1'b0;
      m_irq  <= 1'b0;
`ifdef IRQ_SYNC_EN
      m_s1   <= '0;
      m_s2   <= '0;
`endif
    end else begin
      m_pend <= m_next_pend();
      m_en   <= m_next_en();
      m_gen  <= m_next_gen();
      m_prev <= m_raw();
      m_irq  <= (m_vec() >= 0);
`ifdef IRQ_SYNC_EN
      m_s1   <= irq_in;
      m_s2   <= m_s1;
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
    select = 1'b1; addr = a; wdata = d; we = m;
    tick();
    select = 1'b0; we = 4'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetq = 1'b0; select = 1'b0; rd = 1'b0; we = 4'b0; addr = 2'd0;
    wdata = 32'h0; irq_in = '0;
    tick(); tick();
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a); #1;
      n_vec++;
      if (rdata !== 32'h0) begin
        n_bad++; $display("FAIL reset_reg%0d: got %h want %h", a, rdata, 32'h0);
      end
    end
    n_vec++;
    if (irq_out !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq_out); end
    resetq = 1'b1;
    tick();
  endtask

  task automatic test_edge_w1c();
    wr(2'd1, 32'h8000_0001, 4'hF);
    irq_in[0] = 1'b1; tick(); irq_in[0] = 1'b0;
    repeat (SyncLat) tick();
    addr = 2'd2; #1;
    n_vec++;
    if (rdata !== 32'h1) begin n_bad++; $display("FAIL edge_pend: got %h want %h", rdata, 32'h1); end
    n_vec++;
    if (irq_out !== 1'b0) begin n_bad++; $display("FAIL edge_irq_early: got %b want 0", irq_out); end
    tick(); addr = 2'd3; #1;
    n_vec++;
    if (rdata !== 32'h8000_0000) begin
      n_bad++; $display("FAIL edge_vec: got %h want %h", rdata, 32'h8000_0000);
    end
    n_vec++;
    if (irq_out !== 1'b1) begin n_bad++; $display("FAIL edge_irq: got %b want 1", irq_out); end
    wr(2'd2, 32'h1, 4'hF);
    addr = 2'd2; #1;
    n_vec++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL w1c_pend: got %h want %h", rdata, 32'h0); end
    n_vec++;
    if (irq_out !== 1'b1) begin n_bad++; $display("FAIL w1c_irq_lag: got %b want 1", irq_out); end
    tick();
    n_vec++;
    if (irq_out !== 1'b0) begin n_bad++; $display("FAIL w1c_irq: got %b want 0", irq_out); end
  endtask

  task automatic test_priority_claim();
    wr(2'd1, 32'h8000_0009, 4'hF);
    irq_in = 8'h09; tick(); irq_in = '0;
    repeat (SyncLat + 1) tick();
    addr = 2'd3; #1;
    n_vec++;
    if (rdata !== 32'h8000_0000) begin
      n_bad++; $display("FAIL prio_vec0: got %h want %h", rdata, 32'h8000_0000);
    end
    n_vec++;
    if (irq_out !== 1'b1) begin n_bad++; $display("FAIL prio_irq: got %b want 1", irq_out); end
    select = 1'b1; rd = 1'b1; tick(); select = 1'b0; rd = 1'b0; #1;
    n_vec++;
    if (rdata !== 32'h8000_0003) begin
      n_bad++; $display("FAIL claim_vec3: got %h want %h", rdata, 32'h8000_0003);
    end
    select = 1'b1; rd = 1'b1; tick(); select = 1'b0; rd = 1'b0; #1;
    n_vec++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL claim_vec_none: got %h want %h", rdata, 32'h0); end
    tick();
    n_vec++;
    if (irq_out !== 1'b0) begin n_bad++; $display("FAIL claim_irq: got %b want 0", irq_out); end
  endtask

  task automatic test_level();
    wr(2'd1, 32'h8000_0004, 4'hF);
    irq_in[2] = 1'b1;
    repeat (SyncLat + 2) tick();
    n_vec++;
    if (irq_out !== 1'b1) begin n_bad++; $display("FAIL lvl_irq: got %b want 1", irq_out); end
    wr(2'd2, 32'h4, 4'hF);
    addr = 2'd2; #1;
    n_vec++;
    if (rdata !== 32'h4) begin n_bad++; $display("FAIL lvl_w1c_pend: got %h want %h", rdata, 32'h4); end
    tick();
    n_vec++;
    if (irq_out !== 1'b1) begin n_bad++; $display("FAIL lvl_w1c_irq: got %b want 1", irq_out); end
    irq_in[2] = 1'b0;
    repeat (SyncLat + 1) tick();
    addr = 2'd2; #1;
    n_vec++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL lvl_drop_pend: got %h want %h", rdata, 32'h0); end
    n_vec++;
    if (irq_out !== 1'b1) begin n_bad++; $display("FAIL lvl_drop_lag: got %b want 1", irq_out); end
    tick();
    n_vec++;
    if (irq_out !== 1'b0) begin n_bad++; $display("FAIL lvl_drop_irq: got %b want 0", irq_out); end
  endtask

  task automatic test_set_wins();
    wr(2'd1, 32'h8000_0002, 4'hF);
    irq_in[1] = 1'b1;
    repeat (SyncLat) tick();
    wr(2'd2, 32'h2, 4'hF);
    addr = 2'd2; #1;
    n_vec++;
    if (rdata !== 32'h2) begin n_bad++; $display("FAIL setwin_pend: got %h want %h", rdata, 32'h2); end
    tick();
    n_vec++;
    if (irq_out !== 1'b1) begin n_bad++; $display("FAIL setwin_irq: got %b want 1", irq_out); end
    wr(2'd1, 32'h0000_0002, 4'hF);
    tick();
    n_vec++;
    if (irq_out !== 1'b0) begin n_bad++; $display("FAIL gen_off_irq: got %b want 0", irq_out); end
    addr = 2'd3; #1;
    n_vec++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL gen_off_vec: got %h want %h", rdata, 32'h0); end
    addr = 2'd2; #1;
    n_vec++;
    if (rdata !== 32'h2) begin n_bad++; $display("FAIL gen_off_pend: got %h want %h", rdata, 32'h2); end
    irq_in = '0;
    tick();
  endtask

  task automatic test_async_reset();
    wr(2'd1, 32'h8000_0001, 4'hF);
    irq_in = 8'h01;
    repeat (SyncLat + 2) tick();
    n_vec++;
    if (irq_out !== 1'b1) begin n_bad++; $display("FAIL arst_pre_irq: got %b want 1", irq_out); end
    #2 resetq = 1'b0; #1;
    n_vec++;
    if (irq_out !== 1'b0) begin n_bad++; $display("FAIL arst_irq: got %b want 0", irq_out); end
    addr = 2'd2; #1;
    n_vec++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL arst_pend: got %h want %h", rdata, 32'h0); end
    addr = 2'd1; #1;
    n_vec++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL arst_en: got %h want %h", rdata, 32'h0); end
    tick();
    resetq = 1'b1;
    // Source 0 is still high: the first clock after release captures it
    tick();
    repeat (SyncLat) tick();
    addr = 2'd2; #1;
    n_vec++;
    if (rdata !== 32'h1) begin n_bad++; $display("FAIL arst_first_edge: got %h want %h", rdata, 32'h1); end
    irq_in = '0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      select = 1'b0; rd = 1'b0; we = 4'b0;
      if ($urandom_range(0, 3) == 0) irq_in = N'($urandom);
      case ($urandom_range(0, 3))
        1: begin select = 1'b1; we = 4'($urandom); addr = 2'($urandom); wdata = $urandom; end
        2: begin select = 1'b1; rd = 1'b1; addr = 2'd3; end
        3: addr = 2'($urandom);
        default: ;
      endcase
      #1;
      n_vec++;
      if (rdata !== exp_rdata(addr)) begin
        n_bad++;
        $display("FAIL rand_rdata c=%0d addr=%0d: got %h want %h", c, addr, rdata, exp_rdata(addr));
      end
      n_vec++;
      if (irq_out !== m_irq) begin
        n_bad++; $display("FAIL rand_irq c=%0d: got %b want %b", c, irq_out, m_irq);
      end
      tick();
    end
    select = 1'b0; rd = 1'b0; we = 4'b0;
  endtask

  initial begin
    test_reset();
    test_edge_w1c();
    test_priority_claim();
    test_level();
    test_set_wins();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
